// File: rtl/morse_number_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : morse_number_transmitter                                   |
// | Description : Keys a 4-bit number out as one or two five-element Morse   |
// |               digits with dot = 1 unit, dash = 3 units, 1-unit element   |
// |               gaps and a 3-unit gap between the two digits.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module morse_number_transmitter #(
    parameter int UNIT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] number,
    output logic       morse_out,
    output logic       busy,
    output logic       done
);

    // Counter must reach 3*UNIT_CYCLES-1 (dash or inter-digit gap) without wrapping.
    localparam int C_CNT_W = (3 * UNIT_CYCLES > 1) ? $clog2(3 * UNIT_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_ONE_LIM   = C_CNT_W'(UNIT_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_THREE_LIM = C_CNT_W'(3 * UNIT_CYCLES - 1);

    localparam logic [2:0] C_IDLE     = 3'd0;
    localparam logic [2:0] C_ON       = 3'd1;
    localparam logic [2:0] C_SYM_GAP  = 3'd2;
    localparam logic [2:0] C_CHAR_GAP = 3'd3;
    localparam logic [2:0] C_DONE     = 3'd4;

    logic [2:0]         r_state;
    logic [3:0]         r_number;
    logic [2:0]         r_elem;
    logic               r_digit_idx;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_morse_out;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_nxt;
    logic [3:0]         w_number_nxt;
    logic [2:0]         w_elem_nxt;
    logic               w_digit_idx_nxt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_two_digit;
    logic [3:0]         w_digit;
    logic               w_dash;
    logic [C_CNT_W-1:0] w_limit;
    logic               w_last;

    // Decode the digit currently being sent and whether this element is a dash.
    always_comb begin
        w_two_digit = (r_number >= 4'd10) && (r_number <= 4'd14);
        w_digit     = r_number;
        if (r_number == 4'd15) begin
            w_digit = 4'd0;
        end else if (w_two_digit) begin
            w_digit = r_digit_idx ? (r_number - 4'd10) : 4'd1;
        end
        w_dash = 1'b1;
        if (w_digit == 4'd0) begin
            w_dash = 1'b1;
        end else if (w_digit <= 4'd5) begin
            w_dash = ({1'b0, r_elem} >= w_digit);
        end else begin
            w_dash = ({1'b0, r_elem} < (w_digit - 4'd5));
        end
        // Period length of the current state minus one, in clocks.
        w_limit = C_ONE_LIM;
        if (((r_state == C_ON) && w_dash) || (r_state == C_CHAR_GAP)) begin
            w_limit = C_THREE_LIM;
        end
        w_last = (r_cnt == w_limit);
    end

    // Next-state logic: sequences elements, gaps and digits of the latched number.
    always_comb begin
        w_state_nxt     = r_state;
        w_number_nxt    = r_number;
        w_elem_nxt      = r_elem;
        w_digit_idx_nxt = r_digit_idx;
        w_cnt_nxt       = r_cnt + C_CNT_W'(1);
        case (r_state)
            C_IDLE: begin
                w_cnt_nxt = '0;
                if (start) begin
                    w_state_nxt     = C_ON;
                    w_number_nxt    = number;
                    w_elem_nxt      = 3'd0;
                    w_digit_idx_nxt = 1'b0;
                end
            end
            C_ON: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_elem < 3'd4) begin
                        w_state_nxt = C_SYM_GAP;
                    end else if (w_two_digit && !r_digit_idx) begin
                        w_state_nxt = C_CHAR_GAP;
                    end else begin
                        w_state_nxt = C_DONE;
                    end
                end
            end
            C_SYM_GAP: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = C_ON;
                    w_elem_nxt  = r_elem + 3'd1;
                end
            end
            C_CHAR_GAP: begin
                if (w_last) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = C_ON;
                    w_elem_nxt      = 3'd0;
                    w_digit_idx_nxt = 1'b1;
                end
            end
            C_DONE: begin
                // Start is deliberately not sampled here; the first IDLE cycle takes it.
                w_cnt_nxt   = '0;
                w_state_nxt = C_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = C_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs follow the next state so
    // they are glitch-free flops aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= C_IDLE;
            r_number    <= 4'd0;
            r_elem      <= 3'd0;
            r_digit_idx <= 1'b0;
            r_cnt       <= '0;
            r_morse_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_number    <= w_number_nxt;
            r_elem      <= w_elem_nxt;
            r_digit_idx <= w_digit_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_morse_out <= (w_state_nxt == C_ON);
            r_busy      <= (w_state_nxt == C_ON) || (w_state_nxt == C_SYM_GAP) ||
                           (w_state_nxt == C_CHAR_GAP);
            r_done      <= (w_state_nxt == C_DONE);
        end
    end

    assign morse_out = r_morse_out;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_morse_number_transmitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_morse_number_transmitter                                |
// | Description : Self-checking bench for morse_number_transmitter with a    |
// |               waveform-level reference model and randomized traffic.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_morse_number_transmitter;

    localparam int C_UNIT = 2;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] number;
    logic       morse_out;
    logic       busy;
    logic       done;

    int  n_vec;
    int  n_err;
    bit  exp_q[$];

    morse_number_transmitter #(
        .UNIT_CYCLES(C_UNIT)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .number   (number),
        .morse_out(morse_out),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: expected morse_out level for every busy cycle of a transmission.
    function automatic void build_wave(input int num);
        int digits[$];
        bit dash;
        exp_q.delete();
        if (num < 10)       digits = '{num};
        else if (num == 15) digits = '{0};
        else                digits = '{1, num - 10};
        foreach (digits[di]) begin
            if (di > 0) repeat (3 * C_UNIT) exp_q.push_back(1'b0);
            for (int i = 0; i < 5; i++) begin
                int d = digits[di];
                if (d == 0)      dash = 1'b1;
                else if (d <= 5) dash = (i >= d);
                else             dash = (i < d - 5);
                if (i > 0) repeat (C_UNIT) exp_q.push_back(1'b0);
                repeat ((dash ? 3 : 1) * C_UNIT) exp_q.push_back(1'b1);
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one number; with noise, start and number are jittered while busy
    // and start is also raised during the DONE cycle, which must be ignored.
    task automatic transmit(input int num, input bit noise, input int exp_busy);
        build_wave(num);
        if (exp_busy > 0) check("busy_len", exp_q.size(), exp_busy);
        start  = 1'b1;
        number = 4'(num);
        tick();
        start = 1'b0;
        foreach (exp_q[k]) begin
            check($sformatf("tx%0d_c%0d", num, k), {29'd0, morse_out, busy, done},
                  {29'd0, exp_q[k], 1'b1, 1'b0});
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                number = 4'($urandom);
            end
            tick();
        end
        check($sformatf("done%0d", num), {29'd0, morse_out, busy, done}, 32'b001);
        start = noise;
        tick();
        start = 1'b0;
        check($sformatf("idle%0d", num), {29'd0, morse_out, busy, done}, 32'b000);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        number = 4'd0;
        tick();
        check("reset", {29'd0, morse_out, busy, done}, 32'b000);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_reset", {29'd0, morse_out, busy, done}, 32'b000);

        transmit(1, 1'b0, 34);
        transmit(5, 1'b0, 18);
        transmit(12, 1'b0, 70);
        transmit(15, 1'b0, 38);
        transmit(0, 1'b0, 38);
        transmit(7, 1'b1, 0);

        // Abort number 9 by reset after ten busy cycles.
        build_wave(9);
        start  = 1'b1;
        number = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("pre_abort_c%0d", k), {29'd0, morse_out, busy, done},
                  {29'd0, exp_q[k], 1'b1, 1'b0});
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("abort_now", {29'd0, morse_out, busy, done}, 32'b000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_hold", {29'd0, morse_out, busy, done}, 32'b000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_idle", {29'd0, morse_out, busy, done}, 32'b000);
        end
        transmit(3, 1'b0, 0);

        // Randomized numbers, with and without input noise.
        for (int r = 0; r < 24; r++) begin
            transmit(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) begin
                tick();
                check("gap_idle", {29'd0, morse_out, busy, done}, 32'b000);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_number_transmitter.md
MORSE_NUMBER_TRANSMITTER -- requirements
Module: morse_number_transmitter

Interface
REQ-001 Parameter UNIT_CYCLES, default 25000000, clock cycles per Morse time unit (legal range 1 or more).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to transmit number; sampled only in IDLE.
REQ-005 number  input  4  value to transmit; latched on accepted start.
REQ-006 morse_out  output  1  keyed Morse signal (1 = tone/LED on).
REQ-007 busy  output  1  high from the cycle after an accepted start through the last on-period.
REQ-008 done  output  1  one-cycle pulse at end of transmission.

Function
REQ-009 Number mapping shall match the game decoder: 0-9 send one digit; 10-14 send two digits, "1" then (number-10); 15 sends digit "0".
REQ-010 Each digit shall be 5 elements, index i = 0..4: for d = 1..5, dot if i < d else dash; for d = 6..9, dash if i < d-5 else dot; for d = 0, all dashes.
REQ-011 Dot shall be morse_out high for 1 unit; dash high for 3 units; unit = UNIT_CYCLES clocks exactly.
REQ-012 Gap between elements of a digit shall be morse_out low for 1 unit.
REQ-013 Gap between the two digits of a two-digit number shall be morse_out low for 3 units.
REQ-014 FSM states: IDLE, ON (element high), SYM_GAP (1-unit low), CHAR_GAP (3-unit low), DONE.
REQ-015 IDLE -> ON on start=1; number latched, element index and digit index cleared; morse_out high starting the next cycle.
REQ-016 ON -> SYM_GAP when element time expires and index < 4; ON -> CHAR_GAP when index = 4 and a second digit remains; ON -> DONE when index = 4 and no digit remains.
REQ-017 SYM_GAP -> ON (index+1) after 1 unit; CHAR_GAP -> ON (index 0, next digit) after 3 units.
REQ-018 DONE shall last exactly one cycle with done=1, busy=0, morse_out=0, then return to IDLE.
REQ-019 busy=1 in ON, SYM_GAP, CHAR_GAP; 0 in IDLE and DONE.
REQ-020 start while busy or in DONE shall be ignored; latched number shall not change mid-transmission.
REQ-021 Changes on number outside the accepted-start cycle shall have no effect.
REQ-022 Unit counter shall be sized for UNIT_CYCLES*3 without overflow; no wrap before terminal count.
REQ-023 start in the same cycle DONE returns to IDLE is not accepted; a new start is accepted from the first IDLE cycle.

Reset
REQ-024 rst_n=0 shall immediately force IDLE, morse_out=0, busy=0, done=0, counters and latched number to 0.
REQ-025 Reset asserted mid-transmission shall abort with no done pulse; after release the block waits in IDLE for a new start.
REQ-026 Outputs shall be registered; no combinational path from start/number to outputs.

Verification (UNIT_CYCLES=2)
REQ-027 start with number=1 -> morse_out high 2, then (low 2, high 6) x4; busy for 34 cycles; done pulses on cycle 35 after start.
REQ-028 number=5 -> five 2-cycle highs separated by 2-cycle lows (18 cycles busy), then done.
REQ-029 number=12 -> digit "1" (34 cycles), low 6 cycles, digit "2" (high 2, low 2, high 2, then (low 2, high 6) x3, 30 cycles); busy 70 cycles total; single done.
REQ-030 number=15 -> five dashes (high 6, low 2 between) = 38 busy cycles, identical to number=0.
REQ-031 start pulses and number changes during number=7 transmission -> waveform unchanged (high 6, low 2, high 6, then (low 2, high 2) x3); exactly one done.
REQ-032 rst_n low at cycle 10 of number=9 -> morse_out, busy, done 0 immediately; no done; next start with number=3 transmits correctly.
